fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Packet-level round-robin arbiter in front of a single FIFO write port.
// A requester wins the FIFO in IDLE (one arbitration cycle). It then owns the
// write port in LOCKED until it transfers a word marked last. There is no
// pre-emption and no timeout. The owner's data is muxed straight through to
// the FIFO, and its ready is the inverse of fifo_full.

module fifo_wr_arbiter #(
  parameter  int DATA_BITS = 8,
  parameter  int NUM_REQ   = 4,
  localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATA_BITS-1:0]         fifo_data,
  output logic [GID_W-1:0]             grant_id,
  output logic                         busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  // Most recent packet owner; the round-robin search starts just after it.
  logic [GID_W-1:0]   last_ptr_q, last_ptr_d;

  logic               win_found;
  logic [GID_W-1:0]   win_idx;
  logic               own_valid;
  logic               own_last;
  logic               xfer;

  // Ring successor of a requester index (wraps at NUM_REQ, not at 2**GID_W).
  function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] p);
    if (p == GID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + GID_W'(1);
  endfunction

  // Round-robin search: first valid requester after last_ptr, with wrap.
  always_comb begin
    logic [GID_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = next_idx(last_ptr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Select the current owner's valid, last and data. The data path is
  // muxed by grant_id in every state, so fifo_data is never undriven.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GID_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        fifo_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Only the owner sees ready, and only while LOCKED and the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_q == GID_W'(i)) && !fifo_full;
      end
    end
  end

  assign xfer       = (state_q == LOCKED) && own_valid && !fifo_full;
  assign fifo_wr_en = xfer;

  // Next-state logic: grant on a win in IDLE, release on the last-word transfer.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          busy_d  = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && own_last) begin
          last_ptr_d = grant_q;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
    endcase
  end

  // State registers. Reset points last_ptr at the top index so requester 0
  // has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      last_ptr_q <= GID_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Requester streams are queues. A driver
// presents each queue head and pops it on a handshake. A monitor checks
// every FIFO write against per-requester expected queues, plus an optional
// expected grant order.

module tb_fifo_wr_arbiter;

  localparam int DB = 8;
  localparam int NR = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } word_t;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DB-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DB-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             busy;

  word_t         rq    [NR][$];
  word_t         exp_q [NR][$];
  int            gord[$];
  int            wr_cyc[$];
  logic [NR-1:0] hold = '0;
  int            nvec = 0;
  int            nfail = 0;
  int            cyc = 0;

  fifo_wr_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic l, input logic ex);
    word_t w;
    w.last = l;
    w.data = d;
    rq[i].push_back(w);
    if (ex) exp_q[i].push_back(w);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int maxc);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
      done = (busy == 1'b0) && (gord.size() == 0) && all_empty();
    end
    check(name, done, 1);
  endtask

  task automatic wait_owner(input string name, input int id, input bit need_wr, input int maxc);
    int c;
    bit ok;
    c = 0;
    ok = 1'b0;
    while (!ok && c < maxc) begin
      @(negedge clk);
      c++;
      ok = busy && (int'(grant_id) == id) && (!need_wr || fifo_wr_en);
    end
    check(name, ok, 1);
  endtask

  // Driver: inputs change 1 time unit after each rising edge.
  initial begin : driver
    logic [NR-1:0] acc;
    acc       = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (!rst_n) acc = '0;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !hold[i]) begin
          req_valid[i]            = 1'b1;
          req_data[i*DB +: DB]    = rq[i][0].data;
          req_last[i]             = rq[i][0].last;
        end else begin
          req_valid[i]            = 1'b0;
          req_data[i*DB +: DB]    = 8'hEE;
          req_last[i]             = 1'b0;
        end
      end
    end
  end

  // Monitor: checks each write on the falling edge.
  initial begin : monitor
    int    g;
    word_t w;
    logic  open;
    int    open_id;
    open    = 1'b0;
    open_id = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        open = 1'b0;
      end else begin
        check("no_write_when_full", fifo_wr_en & fifo_full, 0);
        check("ready_onehot", $countones(req_ready) <= 1, 1);
        if (fifo_wr_en) begin
          g = int'(grant_id);
          wr_cyc.push_back(cyc);
          check("ready_matches_owner", req_ready[grant_id], 1);
          if (open) check("no_interleave", g, open_id);
          if (exp_q[g].size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            w = exp_q[g].pop_front();
            check("write_data", fifo_data, w.data);
            open    = !w.last;
            open_id = g;
          end
          if (gord.size() > 0) check("grant_order", g, gord.pop_front());
        end
      end
    end
  end

  initial begin : main
    int len;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four valid, single-beat packets: grants 0,1,2,3,0,... every 2 cycles.
    align();
    wr_cyc.delete();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        put(i, 8'(16 * (i + 1) + k), 1'b1, 1'b1);
        gord.push_back(i);
      end
    end
    drain("a_drain", 200);
    check("a_writes", wr_cyc.size(), 8);
    for (int k = 1; k < 8; k++) begin
      if (k < wr_cyc.size()) check("a_spacing", wr_cyc[k] - wr_cyc[k-1], 2);
    end

    // Requester 2 three-word packet while requester 0 waits.
    align();
    wr_cyc.delete();
    put(2, 8'hA1, 1'b0, 1'b1);
    put(2, 8'hA2, 1'b0, 1'b1);
    put(2, 8'hA3, 1'b1, 1'b1);
    gord.push_back(2); gord.push_back(2); gord.push_back(2); gord.push_back(0);
    wait_owner("b_grant", 2, 1'b0, 20);
    put(0, 8'h05, 1'b1, 1'b1);
    drain("b_drain", 100);
    check("b_writes", wr_cyc.size(), 4);
    if (wr_cyc.size() >= 3) begin
      check("b_contig1", wr_cyc[1] - wr_cyc[0], 1);
      check("b_contig2", wr_cyc[2] - wr_cyc[1], 1);
    end

    // FIFO full for 4 cycles mid-packet.
    align();
    put(1, 8'hB1, 1'b0, 1'b1);
    put(1, 8'hB2, 1'b0, 1'b1);
    put(1, 8'hB3, 1'b0, 1'b1);
    put(1, 8'hB4, 1'b1, 1'b1);
    repeat (4) gord.push_back(1);
    wait_owner("c_grant", 1, 1'b1, 20);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("c_wr_en", fifo_wr_en, 0);
      check("c_ready", req_ready, 0);
      check("c_grant", grant_id, 1);
      check("c_busy", busy, 1);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    drain("c_drain", 50);

    // Owner 3 drops valid for 3 cycles while 0 and 1 are valid.
    align();
    put(3, 8'hC1, 1'b0, 1'b1);
    put(3, 8'hC2, 1'b0, 1'b1);
    put(3, 8'hC3, 1'b1, 1'b1);
    put(0, 8'hD0, 1'b1, 1'b1);
    put(1, 8'hD1, 1'b1, 1'b1);
    gord.push_back(3); gord.push_back(3); gord.push_back(3);
    gord.push_back(0); gord.push_back(1);
    wait_owner("d_grant", 3, 1'b1, 20);
    hold[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("d_busy", busy, 1);
      check("d_wr_en", fifo_wr_en, 0);
      check("d_grant", grant_id, 3);
    end
    hold[3] = 1'b0;
    drain("d_drain", 50);

    // Reset mid-packet, then requester 2 alone.
    align();
    put(0, 8'hE1, 1'b0, 1'b1);
    put(0, 8'hE2, 1'b0, 1'b0);
    put(0, 8'hE3, 1'b1, 1'b0);
    gord.push_back(0);
    wait_owner("e_grant", 0, 1'b1, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("e_busy", busy, 0);
    check("e_grant", grant_id, 0);
    check("e_ready", req_ready, 0);
    check("e_wr_en", fifo_wr_en, 0);
    rq[0].delete();
    put(2, 8'hF1, 1'b1, 1'b1);
    gord.push_back(2);
    align();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("e_regrant_busy", busy, 1);
    check("e_regrant_id", grant_id, 2);
    drain("e_drain", 50);

    // Lone requester, back-to-back packets: one arbitration cycle between.
    align();
    wr_cyc.delete();
    put(2, 8'h61, 1'b1, 1'b1);
    put(2, 8'h62, 1'b1, 1'b1);
    gord.push_back(2); gord.push_back(2);
    drain("g_drain", 50);
    check("g_writes", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) check("g_spacing", wr_cyc[1] - wr_cyc[0], 2);

    // Mixed packets from everyone with fifo_full toggling.
    align();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) begin
        len = int'($urandom_range(1, 3));
        for (int k = 0; k < len; k++) begin
          put(i, 8'(i * 64 + r * 16 + k), (k == len - 1), 1'b1);
        end
      end
    end
    for (int c = 0; c < 600 && !all_empty(); c++) begin
      @(posedge clk);
      #1 fifo_full = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    drain("f_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
